// File: rtl/two_bit_comparator_if.sv
// Bus bundle for two_bit_comparator: customer-code inputs, sample strobe,
// registered comparison flags and the optional statistics counters.
interface two_bit_comparator_if #(
  parameter int unsigned CNT_W = 8
);
  logic [1:0]       musteri1;
  logic [1:0]       musteri2;
  logic             in_valid;
  logic             stat_clr;
  logic             kirmizi;
  logic             yesil;
  logic             sari;
  logic             out_valid;
  logic [CNT_W-1:0] cnt_lt;
  logic [CNT_W-1:0] cnt_gt;
  logic [CNT_W-1:0] cnt_eq;

  modport master (
    output musteri1, musteri2, in_valid, stat_clr,
    input  kirmizi, yesil, sari, out_valid, cnt_lt, cnt_gt, cnt_eq
  );

  modport slave (
    input  musteri1, musteri2, in_valid, stat_clr,
    output kirmizi, yesil, sari, out_valid, cnt_lt, cnt_gt, cnt_eq
  );
endinterface

// File: rtl/two_bit_comparator.sv
// Registered 2-bit unsigned comparator with red/green/yellow flags.
// Define TWO_BIT_COMPARATOR_STATS_EN to build the saturating result counters.
module two_bit_comparator #(
  parameter int unsigned CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  two_bit_comparator_if.slave bus
);

  // RES_NONE only exists between reset and the first sampled pair.
  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_LT   = 2'd1,
    RES_GT   = 2'd2,
    RES_EQ   = 2'd3
  } res_e;

  res_e res_q, res_d;
  logic out_valid_q, out_valid_d;

  always_comb begin
    res_d       = res_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      if (bus.musteri1 < bus.musteri2) begin
        res_d = RES_LT;
      end else if (bus.musteri1 > bus.musteri2) begin
        res_d = RES_GT;
      end else begin
        res_d = RES_EQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= RES_NONE;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.kirmizi   = (res_q == RES_LT);
  assign bus.yesil     = (res_q == RES_GT);
  assign bus.sari      = (res_q == RES_EQ);
  assign bus.out_valid = out_valid_q;

`ifdef TWO_BIT_COMPARATOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_lt_q, cnt_lt_d;
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;
  logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;

  // Clear has priority over counting a pair sampled in the same cycle.
  always_comb begin
    cnt_lt_d = cnt_lt_q;
    cnt_gt_d = cnt_gt_q;
    cnt_eq_d = cnt_eq_q;
    if (bus.stat_clr) begin
      cnt_lt_d = '0;
      cnt_gt_d = '0;
      cnt_eq_d = '0;
    end else if (bus.in_valid) begin
      case (res_d)
        RES_LT: if (cnt_lt_q != CNT_MAX) cnt_lt_d = cnt_lt_q + CNT_W'(1);
        RES_GT: if (cnt_gt_q != CNT_MAX) cnt_gt_d = cnt_gt_q + CNT_W'(1);
        RES_EQ: if (cnt_eq_q != CNT_MAX) cnt_eq_d = cnt_eq_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lt_q <= '0;
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
    end else begin
      cnt_lt_q <= cnt_lt_d;
      cnt_gt_q <= cnt_gt_d;
      cnt_eq_q <= cnt_eq_d;
    end
  end

  assign bus.cnt_lt = cnt_lt_q;
  assign bus.cnt_gt = cnt_gt_q;
  assign bus.cnt_eq = cnt_eq_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = bus.stat_clr;
  assign bus.cnt_lt      = '0;
  assign bus.cnt_gt      = '0;
  assign bus.cnt_eq      = '0;
`endif

endmodule

// File: tb/tb_two_bit_comparator.sv
// Self-checking bench for two_bit_comparator: vector table, corner sequences,
// and randomized traffic against a behavioural model (CNT_W=8 and CNT_W=2).
module tb_two_bit_comparator;
`ifdef TWO_BIT_COMPARATOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  two_bit_comparator_if #(.CNT_W(8)) bus ();
  two_bit_comparator_if #(.CNT_W(2)) bus2 ();

  two_bit_comparator #(.CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  two_bit_comparator #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_k, m_y, m_s, m_ov, m_seen;
  int m_lt, m_gt, m_eq;
  int s_lt, s_gt, s_eq;

  typedef struct {
    logic [1:0] m1;
    logic [1:0] m2;
    logic       k;
    logic       y;
    logic       s;
  } vec_t;

  vec_t vec [16];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int c, input int cap);
    return (c < cap) ? c + 1 : c;
  endfunction

  task automatic model_reset();
    m_k = 0; m_y = 0; m_s = 0; m_ov = 0; m_seen = 0;
    m_lt = 0; m_gt = 0; m_eq = 0;
    s_lt = 0; s_gt = 0; s_eq = 0;
  endtask

  task automatic model_update(input int a, input int b, input int v, input int c);
    m_ov = v;
    if (v != 0) begin
      m_k = (a < b) ? 1 : 0;
      m_y = (a > b) ? 1 : 0;
      m_s = (a == b) ? 1 : 0;
      m_seen = 1;
    end
    if (c != 0) begin
      m_lt = 0; m_gt = 0; m_eq = 0;
      s_lt = 0; s_gt = 0; s_eq = 0;
    end else if (v != 0) begin
      if (a < b) begin
        m_lt = sat_inc(m_lt, 255); s_lt = sat_inc(s_lt, 3);
      end else if (a > b) begin
        m_gt = sat_inc(m_gt, 255); s_gt = sat_inc(s_gt, 3);
      end else begin
        m_eq = sat_inc(m_eq, 255); s_eq = sat_inc(s_eq, 3);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".kirmizi"}, int'(bus.kirmizi), m_k);
    check({tag, ".yesil"}, int'(bus.yesil), m_y);
    check({tag, ".sari"}, int'(bus.sari), m_s);
    check({tag, ".out_valid"}, int'(bus.out_valid), m_ov);
    check({tag, ".onehot"}, int'(bus.kirmizi) + int'(bus.yesil) + int'(bus.sari), m_seen);
    check({tag, ".cnt_lt"}, int'(bus.cnt_lt), STATS ? m_lt : 0);
    check({tag, ".cnt_gt"}, int'(bus.cnt_gt), STATS ? m_gt : 0);
    check({tag, ".cnt_eq"}, int'(bus.cnt_eq), STATS ? m_eq : 0);
    check({tag, ".w2_flags"},
          {29'd0, bus2.kirmizi, bus2.yesil, bus2.sari}, (m_k << 2) | (m_y << 1) | m_s);
    check({tag, ".w2_cnt_lt"}, int'(bus2.cnt_lt), STATS ? s_lt : 0);
    check({tag, ".w2_cnt_gt"}, int'(bus2.cnt_gt), STATS ? s_gt : 0);
    check({tag, ".w2_cnt_eq"}, int'(bus2.cnt_eq), STATS ? s_eq : 0);
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic v, input logic c);
    bus.musteri1  = a; bus.musteri2  = b; bus.in_valid  = v; bus.stat_clr  = c;
    bus2.musteri1 = a; bus2.musteri2 = b; bus2.in_valid = v; bus2.stat_clr = c;
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic v,
                      input logic c, input string tag);
    @(negedge clk);
    drive(a, b, v, c);
    @(posedge clk);
    #1;
    model_update(int'(a), int'(b), int'(v), int'(c));
    check_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int red, green, yellow, pulses;
    int exp_w2_eq [5];
    logic [1:0] ra, rb;
    logic rv, rc;

    vec[0]  = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b1}; vec[1]  = '{2'd0, 2'd1, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{2'd0, 2'd2, 1'b1, 1'b0, 1'b0}; vec[3]  = '{2'd0, 2'd3, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{2'd1, 2'd0, 1'b0, 1'b1, 1'b0}; vec[5]  = '{2'd1, 2'd1, 1'b0, 1'b0, 1'b1};
    vec[6]  = '{2'd1, 2'd2, 1'b1, 1'b0, 1'b0}; vec[7]  = '{2'd1, 2'd3, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{2'd2, 2'd0, 1'b0, 1'b1, 1'b0}; vec[9]  = '{2'd2, 2'd1, 1'b0, 1'b1, 1'b0};
    vec[10] = '{2'd2, 2'd2, 1'b0, 1'b0, 1'b1}; vec[11] = '{2'd2, 2'd3, 1'b1, 1'b0, 1'b0};
    vec[12] = '{2'd3, 2'd0, 1'b0, 1'b1, 1'b0}; vec[13] = '{2'd3, 2'd1, 1'b0, 1'b1, 1'b0};
    vec[14] = '{2'd3, 2'd2, 1'b0, 1'b1, 1'b0}; vec[15] = '{2'd3, 2'd3, 1'b0, 1'b0, 1'b1};
    exp_w2_eq = '{1, 2, 3, 3, 3};

    // Reset state
    rst_n = 1'b0;
    drive(2'd0, 2'd0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep of all 16 input combinations
    red = 0; green = 0; yellow = 0;
    for (int i = 0; i < 16; i++) begin
      step(vec[i].m1, vec[i].m2, 1'b1, 1'b0, "sweep");
      check("sweep.tbl_k", int'(bus.kirmizi), int'(vec[i].k));
      check("sweep.tbl_y", int'(bus.yesil), int'(vec[i].y));
      check("sweep.tbl_s", int'(bus.sari), int'(vec[i].s));
      red += int'(bus.kirmizi); green += int'(bus.yesil); yellow += int'(bus.sari);
    end
    check("sweep.red_total", red, 6);
    check("sweep.green_total", green, 6);
    check("sweep.yellow_total", yellow, 4);
    check("sweep.final_lt", int'(bus.cnt_lt), STATS ? 6 : 0);
    check("sweep.final_gt", int'(bus.cnt_gt), STATS ? 6 : 0);
    check("sweep.final_eq", int'(bus.cnt_eq), STATS ? 4 : 0);
    check("sweep.final_w2_lt", int'(bus2.cnt_lt), STATS ? 3 : 0);

    // Hold: flags stay while in_valid is low and inputs wander
    step(2'd2, 2'd1, 1'b1, 1'b0, "hold_sample");
    pulses = int'(bus.out_valid);
    for (int i = 0; i < 3; i++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, 1'b0, "hold_idle");
      check("hold.yesil", int'(bus.yesil), 1);
      pulses += int'(bus.out_valid);
    end
    check("hold.out_valid_pulses", pulses, 1);

    // Saturation on the 2-bit counter instance
    step(2'd0, 2'd0, 1'b0, 1'b1, "sat_clr");
    for (int i = 0; i < 5; i++) begin
      step(2'(i % 4), 2'(i % 4), 1'b1, 1'b0, "sat");
      check("sat.w2_cnt_eq", int'(bus2.cnt_eq), STATS ? exp_w2_eq[i] : 0);
      check("sat.cnt_eq", int'(bus.cnt_eq), STATS ? i + 1 : 0);
    end

    // Clear wins over a simultaneous sample; flags still update
    step(2'd3, 2'd1, 1'b1, 1'b0, "clr_pre");
    step(2'd0, 2'd3, 1'b1, 1'b1, "clr_and_valid");
    check("clr.kirmizi", int'(bus.kirmizi), 1);
    check("clr.cnt_sum", int'(bus.cnt_lt) + int'(bus.cnt_gt) + int'(bus.cnt_eq), 0);

    // Asynchronous reset between edges, with a pair pending
    step(2'd3, 2'd3, 1'b1, 1'b0, "arst_pre");
    #3;
    drive(2'd1, 2'd2, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst_now");
    @(posedge clk);
    #1;
    check_all("arst_held");
    @(negedge clk);
    drive(2'd0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(2'd2, 2'd0, 1'b0, 1'b0, "post_rst_idle");
    step(2'd1, 2'd2, 1'b1, 1'b0, "post_rst_first");
    check("post_rst.kirmizi", int'(bus.kirmizi), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 9) < 7);
      rc = ($urandom_range(0, 19) == 0);
      step(ra, rb, rv, rc, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/two_bit_comparator.md
TWO_BIT_COMPARATOR -- requirements
Module: two_bit_comparator

Interface
REQ-001 Parameter CNT_W, default 8: width of each statistics counter; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 musteri1  input  2  first customer code, unsigned 0..3.
REQ-005 musteri2  input  2  second customer code, unsigned 0..3.
REQ-006 in_valid  input  1  the musteri1/musteri2 pair is sampled this cycle.
REQ-007 stat_clr  input  1  synchronous clear of all statistics counters.
REQ-008 kirmizi  output  1  red: the last sampled musteri1 < musteri2.
REQ-009 yesil  output  1  green: the last sampled musteri1 > musteri2.
REQ-010 sari  output  1  yellow: the last sampled musteri1 == musteri2.
REQ-011 out_valid  output  1  pulses high for one cycle, one cycle after a sampled pair.
REQ-012 cnt_lt, cnt_gt, cnt_eq  output  CNT_W each  saturating counts of red, green and yellow results.

Function
REQ-013 Compare musteri1 and musteri2 as unsigned 2-bit values; every one of the 16 input combinations is legal.
REQ-014 When in_valid=1 at a rising edge, the comparison result is registered; kirmizi, yesil and sari update on that edge, so latency is 1 cycle.
REQ-015 Exactly one of kirmizi, yesil and sari is high at any time after the first sampled pair (one-hot).
REQ-016 When in_valid=0, kirmizi, yesil and sari hold their previous values.
REQ-017 out_valid is the registered copy of in_valid; it is high for exactly one cycle per sampled pair, including back-to-back pairs.
REQ-018 On each sampled pair, the counter matching the result increments by 1 in the same edge that updates the flags.
REQ-019 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-020 stat_clr=1 zeroes all three counters at the edge; if in_valid=1 in the same cycle, the clear wins and that sample is not counted, but the flags still update.
REQ-021 No combinational path exists from the inputs to any output.

Reset
REQ-022 rst_n=0 immediately forces kirmizi=0, yesil=0, sari=0, out_valid=0 and all counters to 0, independent of clk.
REQ-023 Reset asserted mid-operation discards any pair being sampled; after rst_n deasserts, the first rising edge with in_valid=1 behaves as a normal sample.
REQ-024 All flags are 0 from reset until the first sampled pair; this is the only state in which the flags are not one-hot.

Configuration
REQ-025 Macro TWO_BIT_COMPARATOR_STATS_EN controls the statistics counters.
REQ-026 With TWO_BIT_COMPARATOR_STATS_EN defined, the counters behave per REQ-018 to REQ-020.
REQ-027 Without TWO_BIT_COMPARATOR_STATS_EN, cnt_lt, cnt_gt and cnt_eq are tied to 0, stat_clr is ignored, no counter logic is built, and all other behaviour is unchanged.

Verification
REQ-028 Sweep all 16 combinations (musteri1 0..3 × musteri2 0..3), one per cycle with in_valid=1 -> one cycle later, red for 6 pairs, green for 6 and yellow for 4; one-hot holds every cycle; final cnt_lt=6, cnt_gt=6, cnt_eq=4.
REQ-029 Sample musteri1=2, musteri2=1, then hold in_valid=0 for 3 cycles while changing the inputs -> yesil stays 1 for the whole period and out_valid pulses exactly once.
REQ-030 With CNT_W=2, apply 5 equal pairs -> cnt_eq reads 1, 2, 3, 3, 3.
REQ-031 Apply stat_clr=1 together with in_valid=1 and pair (0,3) -> all counters read 0 and kirmizi=1.
REQ-032 Assert rst_n=0 between clock edges after sampling (3,3) -> flags, out_valid and counters go to 0 at once, before the next clock edge.
REQ-033 Build without TWO_BIT_COMPARATOR_STATS_EN and rerun REQ-028 -> the same flag sequence, with all counters reading 0.
